// File: rtl/esfa_trial_scheduler.sv
// esfa_trial_scheduler
//   Runs a host-requested batch of ESFA core trials. Each trial gets one launch pulse, then a
//   watchdog supervises the core while it starts and while it runs. The block keeps
//   saturating pass/fail tallies and the address of the first failing trial. When a batch
//   ends it reports done, and it also reports whether the watchdog or a host abort ended it.
//
// Ports
//   masterClock       in   clock; all state changes on the rising edge
//   reset             in   synchronous, active-high
//   cmdValid          in   one-cycle command strobe
//   cmdStart          in   1 = start batch, 0 = abort batch
//   cmdCount          in   number of trials in the batch (start only)
//   cmdReady          out  a start command is accepted this cycle
//   coreDoRun         out  registered launch pulse to the core
//   coreIsRunning     in   core busy
//   coreWasSuccessful in   core result, valid after coreIsRunning falls
//   coreFailAddr      in   core failing address
//   busy              out  batch in progress
//   done              out  batch finished; sticky until the next accepted start
//   passCount         out  passed trials (saturating)
//   failCount         out  failed or timed-out trials (saturating)
//   firstFailAddr     out  address of the first failing trial in the batch
//   firstFailValid    out  firstFailAddr holds a capture
//   timeoutFlag       out  batch ended by the watchdog
//   abortFlag         out  batch ended by a host abort
module esfa_trial_scheduler #(
    parameter int unsigned COUNT_W     = 16,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned START_WAIT  = 16,
    parameter int unsigned RUN_TIMEOUT = 1000000
) (
    input  logic               masterClock,
    input  logic               reset,
    input  logic               cmdValid,
    input  logic               cmdStart,
    input  logic [COUNT_W-1:0] cmdCount,
    output logic               cmdReady,
    output logic               coreDoRun,
    input  logic               coreIsRunning,
    input  logic               coreWasSuccessful,
    input  logic [ADDR_W-1:0]  coreFailAddr,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] passCount,
    output logic [COUNT_W-1:0] failCount,
    output logic [ADDR_W-1:0]  firstFailAddr,
    output logic               firstFailValid,
    output logic               timeoutFlag,
    output logic               abortFlag
);

    // The timer is shared by both watchdog phases, so it is sized for the longer one.
    localparam int unsigned TimerMax = (RUN_TIMEOUT > START_WAIT) ? RUN_TIMEOUT : START_WAIT;
    localparam int unsigned TimerW   = $clog2(TimerMax);
    localparam logic [TimerW-1:0] StartLimit = TimerW'(START_WAIT - 1);
    localparam logic [TimerW-1:0] RunLimit   = TimerW'(RUN_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWaitStart,
        StRunning,
        StRecord
    } stateT;

    stateT               stateQ, stateD;
    logic [TimerW-1:0]   timerQ, timerD;
    logic [COUNT_W-1:0]  remainingQ, remainingD;
    logic [COUNT_W-1:0]  passCountQ, passCountD;
    logic [COUNT_W-1:0]  failCountQ, failCountD;
    logic [ADDR_W-1:0]   firstFailAddrQ, firstFailAddrD;
    logic                firstFailValidQ, firstFailValidD;
    logic                doneQ, doneD;
    logic                timeoutFlagQ, timeoutFlagD;
    logic                abortFlagQ, abortFlagD;
    logic                doRunQ;

    logic                abortReq;
    logic                startReq;
    logic [COUNT_W-1:0]  passInc;
    logic [COUNT_W-1:0]  failInc;

    assign cmdReady = (stateQ == StIdle) && !coreIsRunning;
    assign abortReq = cmdValid && !cmdStart;
    assign startReq = cmdValid && cmdStart && cmdReady;

    // Saturating increments: the tallies stick at all-ones instead of wrapping.
    assign passInc = (passCountQ == '1) ? passCountQ : passCountQ + 1'b1;
    assign failInc = (failCountQ == '1) ? failCountQ : failCountQ + 1'b1;

    always_comb begin
        stateD          = stateQ;
        timerD          = timerQ;
        remainingD      = remainingQ;
        passCountD      = passCountQ;
        failCountD      = failCountQ;
        firstFailAddrD  = firstFailAddrQ;
        firstFailValidD = firstFailValidQ;
        doneD           = doneQ;
        timeoutFlagD    = timeoutFlagQ;
        abortFlagD      = abortFlagQ;

        if ((stateQ != StIdle) && abortReq) begin
            // An abort beats a same-cycle result or timeout. The in-flight trial is dropped.
            stateD     = StIdle;
            abortFlagD = 1'b1;
            doneD      = 1'b1;
        end else begin
            unique case (stateQ)
                StIdle: begin
                    if (startReq) begin
                        passCountD      = '0;
                        failCountD      = '0;
                        firstFailAddrD  = '0;
                        firstFailValidD = 1'b0;
                        timeoutFlagD    = 1'b0;
                        abortFlagD      = 1'b0;
                        remainingD      = cmdCount;
                        if (cmdCount == '0) begin
                            // Empty batch: finish at once without launching the core.
                            doneD = 1'b1;
                        end else begin
                            doneD  = 1'b0;
                            stateD = StLaunch;
                        end
                    end
                end

                StLaunch: begin
                    timerD = '0;
                    stateD = StWaitStart;
                end

                StWaitStart: begin
                    if (coreIsRunning) begin
                        timerD = '0;
                        stateD = StRunning;
                    end else if (timerQ == StartLimit) begin
                        failCountD   = failInc;
                        timeoutFlagD = 1'b1;
                        doneD        = 1'b1;
                        stateD       = StIdle;
                    end else begin
                        timerD = timerQ + 1'b1;
                    end
                end

                StRunning: begin
                    if (!coreIsRunning) begin
                        stateD = StRecord;
                    end else if (timerQ == RunLimit) begin
                        failCountD   = failInc;
                        timeoutFlagD = 1'b1;
                        doneD        = 1'b1;
                        stateD       = StIdle;
                    end else begin
                        timerD = timerQ + 1'b1;
                    end
                end

                StRecord: begin
                    if (coreWasSuccessful) begin
                        passCountD = passInc;
                    end else begin
                        failCountD = failInc;
                        if (!firstFailValidQ) begin
                            firstFailAddrD  = coreFailAddr;
                            firstFailValidD = 1'b1;
                        end
                    end
                    if (remainingQ == COUNT_W'(1)) begin
                        doneD  = 1'b1;
                        stateD = StIdle;
                    end else begin
                        remainingD = remainingQ - 1'b1;
                        stateD     = StLaunch;
                    end
                end

                default: stateD = StIdle;
            endcase
        end
    end

    always_ff @(posedge masterClock) begin
        if (reset) begin
            stateQ          <= StIdle;
            timerQ          <= '0;
            remainingQ      <= '0;
            passCountQ      <= '0;
            failCountQ      <= '0;
            firstFailAddrQ  <= '0;
            firstFailValidQ <= 1'b0;
            doneQ           <= 1'b0;
            timeoutFlagQ    <= 1'b0;
            abortFlagQ      <= 1'b0;
            doRunQ          <= 1'b0;
        end else begin
            stateQ          <= stateD;
            timerQ          <= timerD;
            remainingQ      <= remainingD;
            passCountQ      <= passCountD;
            failCountQ      <= failCountD;
            firstFailAddrQ  <= firstFailAddrD;
            firstFailValidQ <= firstFailValidD;
            doneQ           <= doneD;
            timeoutFlagQ    <= timeoutFlagD;
            abortFlagQ      <= abortFlagD;
            // Registered so the pulse is high during exactly the launch cycle.
            doRunQ          <= (stateD == StLaunch);
        end
    end

    assign coreDoRun      = doRunQ;
    assign busy           = (stateQ != StIdle);
    assign done           = doneQ;
    assign passCount      = passCountQ;
    assign failCount      = failCountQ;
    assign firstFailAddr  = firstFailAddrQ;
    assign firstFailValid = firstFailValidQ;
    assign timeoutFlag    = timeoutFlagQ;
    assign abortFlag      = abortFlagQ;

endmodule

// File: tb/tb_esfa_trial_scheduler.sv
// tb_esfa_trial_scheduler
//   Directed bench for esfa_trial_scheduler. A behavioural core answers each launch pulse.
//   It raises isRunning, holds it for a set number of cycles, then drops it and presents a
//   result taken from a per-trial table.
module tb_esfa_trial_scheduler;

    localparam int unsigned CW = 16;
    localparam int unsigned AW = 32;
    localparam int unsigned SW = 16;
    localparam int unsigned RT = 20;

    logic          masterClock = 1'b0;
    logic          reset       = 1'b1;
    logic          cmdValid    = 1'b0;
    logic          cmdStart    = 1'b0;
    logic [CW-1:0] cmdCount    = '0;
    logic          cmdReady;
    logic          coreDoRun;
    logic          coreIsRunning     = 1'b0;
    logic          coreWasSuccessful = 1'b0;
    logic [AW-1:0] coreFailAddr      = '0;
    logic          busy;
    logic          done;
    logic [CW-1:0] passCount;
    logic [CW-1:0] failCount;
    logic [AW-1:0] firstFailAddr;
    logic          firstFailValid;
    logic          timeoutFlag;
    logic          abortFlag;

    esfa_trial_scheduler #(
        .COUNT_W    (CW),
        .ADDR_W     (AW),
        .START_WAIT (SW),
        .RUN_TIMEOUT(RT)
    ) dut (
        .masterClock      (masterClock),
        .reset            (reset),
        .cmdValid         (cmdValid),
        .cmdStart         (cmdStart),
        .cmdCount         (cmdCount),
        .cmdReady         (cmdReady),
        .coreDoRun        (coreDoRun),
        .coreIsRunning    (coreIsRunning),
        .coreWasSuccessful(coreWasSuccessful),
        .coreFailAddr     (coreFailAddr),
        .busy             (busy),
        .done             (done),
        .passCount        (passCount),
        .failCount        (failCount),
        .firstFailAddr    (firstFailAddr),
        .firstFailValid   (firstFailValid),
        .timeoutFlag      (timeoutFlag),
        .abortFlag        (abortFlag)
    );

    always #5 masterClock = ~masterClock;

    int total = 0;
    int bad   = 0;

    // Core model state
    bit            modelEnable = 1'b1;
    int            modelRunLen = 10;
    int            runLeft     = 0;
    logic [2:0]    modelIdx    = '0;
    bit            modelPass [0:7];
    logic [AW-1:0] modelAddr [0:7];
    int            pulses      = 0;
    int            highCycles  = 0;
    logic          prevDoRun   = 1'b0;

    initial begin
        forever begin
            @(negedge masterClock);
            if (coreDoRun === 1'b1) begin
                highCycles++;
                if (prevDoRun !== 1'b1) pulses++;
            end
            prevDoRun = coreDoRun;
            if (runLeft > 0) begin
                runLeft--;
                if (runLeft == 0) begin
                    coreIsRunning     = 1'b0;
                    coreWasSuccessful = modelPass[modelIdx];
                    coreFailAddr      = modelAddr[modelIdx];
                    modelIdx          = modelIdx + 3'd1;
                end
            end else if (coreDoRun === 1'b1 && modelEnable) begin
                coreIsRunning     = 1'b1;
                coreWasSuccessful = 1'b0;
                runLeft           = modelRunLen;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "global timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled just after the falling edge.
    task automatic step();
        @(negedge masterClock);
        #1;
    endtask

    task automatic cmd(input logic start, input logic [CW-1:0] cnt);
        cmdValid = 1'b1;
        cmdStart = start;
        cmdCount = cnt;
        step();
        cmdValid = 1'b0;
        cmdStart = 1'b0;
        cmdCount = '0;
    endtask

    task automatic waitDone(input int budget, input string tag);
        for (int i = 0; i < budget && done !== 1'b1; i++) step();
        check(tag, done, 1);
    endtask

    task automatic waitPulses(input int n, input int budget, input string tag);
        for (int i = 0; i < budget && pulses < n; i++) step();
        check(tag, pulses, n);
    endtask

    task automatic waitFall(input int budget, input string tag);
        for (int i = 0; i < budget && coreIsRunning; i++) step();
        check(tag, coreIsRunning, 0);
    endtask

    task automatic setAllPass();
        for (int i = 0; i < 8; i++) begin
            modelPass[i] = 1'b1;
            modelAddr[i] = 32'hFFFF_0000 + i;
        end
        modelIdx = '0;
    endtask

    initial begin
        setAllPass();

        // 1: reset held two cycles
        reset = 1'b1;
        step();
        step();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dorun", coreDoRun, 0);
        check("rst_pass", passCount, 0);
        check("rst_fail", failCount, 0);
        check("rst_ffaddr", firstFailAddr, 0);
        check("rst_ffvalid", firstFailValid, 0);
        check("rst_timeout", timeoutFlag, 0);
        check("rst_abort", abortFlag, 0);
        reset = 1'b0;
        step();
        check("rst_ready", cmdReady, 1);

        // 2: three passing trials
        pulses = 0;
        highCycles = 0;
        cmd(1'b1, 16'd3);
        check("t2_dorun_latency", coreDoRun, 1);
        check("t2_busy", busy, 1);
        waitDone(200, "t2_done");
        check("t2_pass", passCount, 3);
        check("t2_fail", failCount, 0);
        check("t2_busy_end", busy, 0);
        check("t2_pulses", pulses, 3);
        check("t2_high_cycles", highCycles, 3);
        check("t2_ffvalid", firstFailValid, 0);

        // 3: trials 2 and 4 fail
        setAllPass();
        modelPass[1] = 1'b0;
        modelAddr[1] = 32'h0000_1234;
        modelPass[3] = 1'b0;
        modelAddr[3] = 32'h0000_DEAD;
        cmd(1'b1, 16'd4);
        check("t3_done_cleared", done, 0);
        waitDone(300, "t3_done");
        check("t3_pass", passCount, 2);
        check("t3_fail", failCount, 2);
        check("t3_ffaddr", firstFailAddr, 32'h0000_1234);
        check("t3_ffvalid", firstFailValid, 1);
        check("t3_timeout", timeoutFlag, 0);

        // 4: core never starts; done lands 17 cycles after the launch pulse
        modelEnable = 1'b0;
        pulses = 0;
        cmd(1'b1, 16'd1);
        check("t4_dorun", coreDoRun, 1);
        repeat (16) step();
        check("t4_done_early", done, 0);
        step();
        check("t4_done_at_17", done, 1);
        check("t4_timeout", timeoutFlag, 1);
        check("t4_fail", failCount, 1);
        check("t4_pass", passCount, 0);
        check("t4_ffvalid", firstFailValid, 0);
        check("t4_ffaddr", firstFailAddr, 0);
        check("t4_pulses", pulses, 1);
        modelEnable = 1'b1;

        // 4b: core runs past the run watchdog (RUN_TIMEOUT=20)
        setAllPass();
        modelRunLen = 50;
        cmd(1'b1, 16'd1);
        repeat (21) step();
        check("t4b_done_early", done, 0);
        step();
        check("t4b_done_at_22", done, 1);
        check("t4b_timeout", timeoutFlag, 1);
        check("t4b_fail", failCount, 1);
        check("t4b_ready_while_running", cmdReady, 0);
        waitFall(60, "t4b_fall");
        check("t4b_ready_after_fall", cmdReady, 1);
        modelRunLen = 10;

        // 5: abort during trial 2 of 5
        setAllPass();
        pulses = 0;
        cmd(1'b1, 16'd5);
        waitPulses(2, 100, "t5_second_launch");
        repeat (3) step();
        check("t5_pass_before_abort", passCount, 1);
        cmd(1'b0, 16'd0);
        check("t5_abort", abortFlag, 1);
        check("t5_done", done, 1);
        check("t5_busy", busy, 0);
        check("t5_ready_low", cmdReady, 0);
        cmd(1'b1, 16'd3);
        check("t5_start_ignored_busy", busy, 0);
        check("t5_start_ignored_abort", abortFlag, 1);
        waitFall(20, "t5_fall");
        check("t5_ready_after_fall", cmdReady, 1);
        repeat (3) step();
        check("t5_no_more_launch", pulses, 2);
        check("t5_pass_final", passCount, 1);
        check("t5_fail_final", failCount, 0);

        // 5b: abort in the same cycle that isRunning falls
        setAllPass();
        pulses = 0;
        cmd(1'b1, 16'd2);
        check("t5b_abort_cleared", abortFlag, 0);
        for (int i = 0; i < 30; i++) begin
            step();
            if (!coreIsRunning) break;
        end
        check("t5b_fall_seen", coreIsRunning, 0);
        cmd(1'b0, 16'd0);
        check("t5b_abort", abortFlag, 1);
        check("t5b_pass", passCount, 0);
        check("t5b_fail", failCount, 0);
        check("t5b_busy", busy, 0);
        repeat (4) step();
        check("t5b_pulses", pulses, 1);

        // 6: zero-length batch
        pulses = 0;
        cmd(1'b1, 16'd0);
        check("t6_done", done, 1);
        check("t6_busy", busy, 0);
        check("t6_dorun", coreDoRun, 0);
        check("t6_abort_cleared", abortFlag, 0);
        step();
        check("t6_no_pulse", pulses, 0);

        // 6b: reset in the middle of a running trial
        setAllPass();
        cmd(1'b1, 16'd2);
        waitPulses(2, 100, "t6b_second_launch");
        repeat (3) step();
        check("t6b_pass_before_reset", passCount, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6b_busy", busy, 0);
        check("t6b_pass", passCount, 0);
        check("t6b_fail", failCount, 0);
        check("t6b_done", done, 0);
        check("t6b_dorun", coreDoRun, 0);
        step();
        check("t6b_dorun_after", coreDoRun, 0);
        waitFall(20, "t6b_fall");
        check("t6b_ready", cmdReady, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
